vx_avs_mem_responder: RTL and testbench



---
 rtl/vx_avs_mem_pkg.sv | 30 +++
 rtl/vx_avs_rd_pipe.sv | 45 ++++
 rtl/vx_avs_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_vx_avs_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_avs_mem_pkg.sv
// vx_avs_mem_pkg
// Shared types and constants for the Avalon-MM local-memory bank responder.
//   t_avs_data / t_avs_addr / t_avs_burst / t_avs_be : default-width bus types
//   t_avs_rsp_state                                   : responder FSM states
//   AVS_LFSR_SEED / avs_lfsr_next                     : stall-injection LFSR
package vx_avs_mem_pkg;

  localparam int AVS_DATA_W  = 512;
  localparam int AVS_ADDR_W  = 26;
  localparam int AVS_BURST_W = 7;

  typedef logic [AVS_DATA_W-1:0]   t_avs_data;
  typedef logic [AVS_ADDR_W-1:0]   t_avs_addr;
  typedef logic [AVS_BURST_W-1:0]  t_avs_burst;
  typedef logic [AVS_DATA_W/8-1:0] t_avs_be;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } t_avs_rsp_state;

  localparam logic [15:0] AVS_LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11 (bit 16 is the MSB).
  function automatic logic [15:0] avs_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/vx_avs_rd_pipe.sv
// vx_avs_rd_pipe
// Fixed-latency read-return pipe: STAGES-deep valid+data shift register.
// A beat entering on i_vld/i_data appears on o_vld/o_data STAGES cycles later.
//   i_clk  : clock
//   i_clr  : synchronous clear of every stage (valids and data)
//   i_vld  : beat issued this cycle
//   i_data : data sampled from storage at issue
//   o_vld  : beat valid at the pipe output
//   o_data : beat data at the pipe output
module vx_avs_rd_pipe #(
  parameter int DATA_W = 512,
  parameter int STAGES = 4
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);

  logic              r_vld_p  [STAGES];
  logic [DATA_W-1:0] r_data_p [STAGES];

  // Data stages are cleared as well so the output bus reads zero out of reset.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld_p[s]  <= 1'b0;
        r_data_p[s] <= '0;
      end
    end else begin
      r_vld_p[0]  <= i_vld;
      r_data_p[0] <= i_data;
      for (int s = 1; s < STAGES; s++) begin
        r_vld_p[s]  <= r_vld_p[s-1];
        r_data_p[s] <= r_data_p[s-1];
      end
    end
  end

  assign o_vld  = r_vld_p[STAGES-1];
  assign o_data = r_data_p[STAGES-1];

endmodule

// File: rtl/vx_avs_mem_responder.sv
// vx_avs_mem_responder
// Avalon-MM responder modelling one local-memory bank. Accepts read/write
// bursts, stores writes with byte enables, returns read beats after a fixed
// READ_LATENCY, and raises a sticky flag on illegal commands.
// Optional random stall injection: define VX_AVS_MEM_STALL_EN.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   avs_address         : word address (first beat only)
//   avs_read/avs_write  : read request / write beat valid
//   avs_writedata       : write data
//   avs_byteenable      : per-byte write enable
//   avs_burstcount      : beats in burst (first beat only)
//   avs_waitrequest     : command/beat not accepted this cycle
//   avs_readdata        : read data
//   avs_readdatavalid   : read data valid
//   protocol_error      : sticky illegal-command flag
module vx_avs_mem_responder
  import vx_avs_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int BURST_WIDTH    = 7,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int READ_LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic [BURST_WIDTH-1:0]  avs_burstcount,
  output logic                    avs_waitrequest,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    protocol_error
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;

  logic [DATA_WIDTH-1:0]     r_mem [MEM_WORDS];
  t_avs_rsp_state            r_state;
  logic [MEM_DEPTH_LOG2-1:0] r_addr;
  logic [BURST_WIDTH-1:0]    r_remaining;
  logic                      r_perr;

  logic                      w_stall;
  logic                      w_waitreq;
  logic                      w_accept;
  logic                      w_wr_en;
  logic                      w_rd_issue;
  logic                      w_err;
  logic [MEM_DEPTH_LOG2-1:0] w_idx;
  logic [BURST_WIDTH-1:0]    w_burst_n;
  logic [DATA_WIDTH-1:0]     w_rd_data;
  logic                      w_unused_addr;

  // Address bits above the storage depth are intentionally ignored.
  assign w_unused_addr = ^avs_address;

`ifdef VX_AVS_MEM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= AVS_LFSR_SEED;
    else       r_lfsr <= avs_lfsr_next(r_lfsr);
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_waitreq  = reset | (r_state == RD_BURST) | w_stall;
    w_accept   = (avs_read | avs_write) & ~w_waitreq;
    // A zero burstcount is served as a single beat.
    w_burst_n  = (avs_burstcount == '0) ? BURST_WIDTH'(1) : avs_burstcount;
    w_idx      = avs_address[MEM_DEPTH_LOG2-1:0];
    w_wr_en    = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      IDLE: begin
        // On a read/write collision the write wins and the read is dropped.
        if (avs_write && !w_waitreq)     w_wr_en    = 1'b1;
        else if (avs_read && !w_waitreq) w_rd_issue = 1'b1;
      end
      WR_BURST: begin
        w_idx   = r_addr;
        w_wr_en = avs_write & ~w_waitreq;
      end
      RD_BURST: begin
        // Read issue ignores stalls so latency and ordering are unaffected.
        w_idx      = r_addr;
        w_rd_issue = 1'b1;
      end
      default: ;
    endcase
    w_err = ((r_state == IDLE) && w_accept &&
             ((avs_burstcount == '0) || (avs_read && avs_write))) ||
            ((r_state == WR_BURST) && avs_read);
  end

  // Reads sample storage at issue time, so a completed write is visible.
  assign w_rd_data = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avs_byteenable[b]) r_mem[w_idx][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_perr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_en || w_rd_issue) begin
            r_addr      <= w_idx + 1'b1;
            r_remaining <= w_burst_n - 1'b1;
            if (w_burst_n != BURST_WIDTH'(1)) r_state <= w_wr_en ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST: begin
          if (w_wr_en) begin
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == BURST_WIDTH'(1)) r_state <= IDLE;
          end
        end
        RD_BURST: begin
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == BURST_WIDTH'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_err) r_perr <= 1'b1;
    end
  end

  vx_avs_rd_pipe #(
    .DATA_W (DATA_WIDTH),
    .STAGES (READ_LATENCY)
  ) u_rd_pipe (
    .i_clk  (clk),
    .i_clr  (reset),
    .i_vld  (w_rd_issue),
    .i_data (w_rd_data),
    .o_vld  (avs_readdatavalid),
    .o_data (avs_readdata)
  );

  assign avs_waitrequest = w_waitreq;
  assign protocol_error  = r_perr;

endmodule

// File: tb/tb_vx_avs_mem_responder.sv
module tb_vx_avs_mem_responder;
  import vx_avs_mem_pkg::*;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       reset;
  t_avs_addr  avs_address;
  logic       avs_read;
  logic       avs_write;
  t_avs_data  avs_writedata;
  t_avs_be    avs_byteenable;
  t_avs_burst avs_burstcount;
  logic       avs_waitrequest;
  t_avs_data  avs_readdata;
  logic       avs_readdatavalid;
  logic       protocol_error;

  always #5 clk = ~clk;

  vx_avs_mem_responder #(
    .DATA_WIDTH     (512),
    .ADDR_WIDTH     (26),
    .BURST_WIDTH    (7),
    .MEM_DEPTH_LOG2 (12),
    .READ_LATENCY   (L)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .protocol_error    (protocol_error)
  );

  int        cyc = 0;
  t_avs_data rq_data[$];
  int        rq_cyc[$];
  int        n_checks = 0;
  int        n_fail = 0;
  t_avs_data edata[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      rq_data.push_back(avs_readdata);
      rq_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the current drive until a cycle without waitrequest; t is that cycle.
  task automatic wait_accept(input string tag, output int t);
    int tries = 0;
    bit acc;
    t = 0;
    do begin
      @(negedge clk);
      acc = !avs_waitrequest;
      t = cyc;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) chk({tag, "_timeout"}, 512'(acc), 512'(1));
  endtask

  task automatic do_write(input int addr, input int bc, input int nb, input t_avs_be be,
                          input int rd_mask, input string tag);
    int t;
    for (int b = 0; b < nb; b++) begin
      avs_write      = 1'b1;
      avs_read       = rd_mask[b];
      avs_address    = (b == 0) ? 26'(addr) : 26'h3ABCD;
      avs_burstcount = (b == 0) ? 7'(bc) : 7'h55;
      avs_writedata  = edata[b];
      avs_byteenable = be;
      wait_accept(tag, t);
    end
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic do_read(input int addr, input int bc, output int t, input string tag);
    avs_read       = 1'b1;
    avs_address    = 26'(addr);
    avs_burstcount = 7'(bc);
    wait_accept(tag, t);
    avs_read = 1'b0;
  endtask

  task automatic expect_reads(input int t, input int n, input string tag);
    int g = 0;
    while (rq_data.size() < n && g < 64) begin
      tick();
      g++;
    end
    chk({tag, "_cnt"}, 512'(rq_data.size()), 512'(n));
    for (int k = 0; k < n && k < rq_data.size(); k++) begin
      chk($sformatf("%s_d%0d", tag, k), rq_data[k], edata[k]);
      chk($sformatf("%s_t%0d", tag, k), 512'(rq_cyc[k]), 512'(t + L + k));
    end
    rq_data.delete();
    rq_cyc.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset          = 1'b1;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    avs_burstcount = '0;
    repeat (3) tick();
    chk("rst_rdv",   512'(avs_readdatavalid), 512'(0));
    chk("rst_rdata", avs_readdata, 512'(0));
    chk("rst_perr",  512'(protocol_error), 512'(0));
    chk("rst_wait",  512'(avs_waitrequest), 512'(1));
    reset = 1'b0;
    tick();
`ifndef VX_AVS_MEM_STALL_EN
    chk("idle_wait", 512'(avs_waitrequest), 512'(0));
`endif

    // single write then single read
    edata[0] = {64{8'hA5}};
    do_write(32'h10, 1, 1, '1, 0, "w1");
    do_read(32'h10, 1, t, "r1");
    expect_reads(t, 1, "r1");
    chk("r1_perr", 512'(protocol_error), 512'(0));

    // 4-beat write burst then 4-beat read burst
    for (int i = 0; i < 4; i++) edata[i] = 512'(i + 1);
    do_write(32'h20, 4, 4, '1, 0, "wb");
    do_read(32'h20, 4, t, "rb");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rb_wait%0d", i), 512'(avs_waitrequest), 512'(1));
    end
`ifndef VX_AVS_MEM_STALL_EN
    @(negedge clk);
    chk("rb_wait_end", 512'(avs_waitrequest), 512'(0));
`endif
    expect_reads(t, 4, "rb");

    // byte enable: only byte 0 of an all-ones write lands
    edata[0] = '0;
    do_write(32'h30, 1, 1, '1, 0, "bz");
    edata[0] = '1;
    do_write(32'h30, 1, 1, t_avs_be'(1), 0, "be");
    do_read(32'h30, 1, t, "rbe");
    edata[0] = 512'hFF;
    expect_reads(t, 1, "rbe");

    // burst wraps from index 0xFFF to 0x000
    edata[0] = 512'h111;
    edata[1] = 512'h222;
    do_write(32'hFFF, 2, 2, '1, 0, "wrap");
    do_read(32'h000, 1, t, "rw0");
    edata[0] = 512'h222;
    expect_reads(t, 1, "rw0");
    do_read(32'hFFF, 1, t, "rwf");
    edata[0] = 512'h111;
    expect_reads(t, 1, "rwf");

    // reset during the second cycle of an 8-beat read burst
    for (int i = 0; i < 8; i++) edata[i] = 512'(32'h40 + i);
    do_write(32'h40, 8, 8, '1, 0, "w8");
    do_read(32'h40, 8, t, "r8");
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_rdv", 512'(avs_readdatavalid), 512'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdv2", 512'(avs_readdatavalid), 512'(0));
`ifndef VX_AVS_MEM_STALL_EN
    chk("rst_mid_idle", 512'(avs_waitrequest), 512'(0));
`endif
    repeat (10) tick();
    chk("rst_flush_cnt", 512'(rq_data.size()), 512'(0));
    rq_data.delete();
    rq_cyc.delete();
    do_read(32'h40, 8, t, "r8b");
    expect_reads(t, 8, "r8b");

    // burstcount 0 is served as one beat and flags an error
    chk("perr_pre", 512'(protocol_error), 512'(0));
    do_read(32'h10, 0, t, "bc0");
    edata[0] = {64{8'hA5}};
    expect_reads(t, 1, "bc0");
    chk("bc0_perr", 512'(protocol_error), 512'(1));
    tick();
    chk("bc0_sticky", 512'(protocol_error), 512'(1));
    pulse_reset();
    chk("perr_clr", 512'(protocol_error), 512'(0));

    // read+write collision in IDLE: write wins, read dropped
    edata[0] = 512'h77;
    do_write(32'h50, 1, 1, '1, 1, "col");
    repeat (10) tick();
    chk("col_nord", 512'(rq_data.size()), 512'(0));
    chk("col_perr", 512'(protocol_error), 512'(1));
    do_read(32'h50, 1, t, "colr");
    expect_reads(t, 1, "colr");
    chk("col_sticky", 512'(protocol_error), 512'(1));
    pulse_reset();

    // read asserted during a write burst is ignored but flagged
    edata[0] = 512'h88;
    edata[1] = 512'h99;
    do_write(32'h60, 2, 2, '1, 2, "wrr");
    chk("wrr_perr", 512'(protocol_error), 512'(1));
    pulse_reset();
    do_read(32'h61, 1, t, "wrrr");
    edata[0] = 512'h99;
    expect_reads(t, 1, "wrrr");

`ifdef VX_AVS_MEM_STALL_EN
    // long bursts under random stalls
    for (int i = 0; i < 16; i++) edata[i] = 512'(i * 3 + 5);
    do_write(32'h100, 16, 16, '1, 0, "sw");
    do_read(32'h100, 16, t, "sr");
    expect_reads(t, 16, "sr");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
